sha3_padder: RTL and testbench

- Upstream stage of PERMUTATION_MODULE.
- Accepts a message as a stream of 64-bit words with valid/ready handshake.
- Packs the words into R_BLOCK_SIZE-bit rate blocks and applies the Keccak/SHA-3 pad10*1 padding with a domain suffix.
- Presents each completed block, held stable, to the absorb/permutation stage, with first/last flags.

---
 rtl/sha3_padder.sv | 210 +++++++++++++++++++++
 tb/tb_sha3_padder.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha3_padder.sv
// sha3_padder
//
// Front end of the Keccak absorb path. Message words arrive 64 bits at a
// time over a valid/ready handshake. They are packed into R_BLOCK_SIZE-bit
// rate blocks, and the final block receives pad10*1 padding with a
// domain-separation suffix. Each finished block is held stable on BLOCK_OUT
// until the permutation stage takes it.
//
// Ports
//   CLK          rising-edge clock
//   A_RST        asynchronous active-high reset
//   IN_DATA      message word, first byte in [63:56]
//   IN_VALID     IN_DATA / IN_LAST / IN_BYTES are valid
//   IN_READY     a word is accepted this cycle (only while filling)
//   IN_LAST      this word ends the message
//   IN_BYTES     valid leading bytes of the last word (0..8, >8 means 8)
//   BLOCK_OUT    rate block, message byte k at bits [8k:8k+7]
//   BLOCK_VALID  BLOCK_OUT holds a complete block
//   BLOCK_READY  downstream consumes the block
//   BLOCK_FIRST  first block of a message (absorb into zero state)
//   BLOCK_LAST   final, padded block of a message
//   MSG_BYTES    running byte count of the current message
//                (present only when SHA3_PADDER_LEN_CNT_EN is defined)
//
// Optional feature macro: SHA3_PADDER_LEN_CNT_EN

module sha3_padder #(
  parameter int         R_BLOCK_SIZE = 1152,
  parameter logic [7:0] SUFFIX       = 8'h06
) (
  input  logic                    CLK,
  input  logic                    A_RST,
  input  logic [63:0]             IN_DATA,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic                    IN_LAST,
  input  logic [3:0]              IN_BYTES,
  output logic [0:R_BLOCK_SIZE-1] BLOCK_OUT,
  output logic                    BLOCK_VALID,
  input  logic                    BLOCK_READY,
  output logic                    BLOCK_FIRST,
  output logic                    BLOCK_LAST
`ifdef SHA3_PADDER_LEN_CNT_EN
  ,
  output logic [31:0]             MSG_BYTES
`endif
);

  localparam int W     = R_BLOCK_SIZE / 64;
  localparam int NB    = R_BLOCK_SIZE / 8;
  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    FILL,
    EMIT,
    PAD
  } state_t;

  state_t                    state;
  logic [CNT_W-1:0]          word_cnt;
  logic                      first_flag;
  logic                      pad_owed;
  logic                      in_xfer;
  logic                      out_xfer;
  int                        take_bytes;
  int                        pad_pos;
  logic [0:R_BLOCK_SIZE-1]   fill_block;
  logic [0:R_BLOCK_SIZE-1]   pad_block;

  // Words are taken only while filling. A_RST is also folded in because the
  // state register already sits at FILL while reset is held.
  assign IN_READY = (state == FILL) && !A_RST;
  assign in_xfer  = IN_VALID && IN_READY;
  assign out_xfer = BLOCK_VALID && BLOCK_READY;

  // Count of bytes taken from the current word. On the last word this also
  // gives the position of the first pad byte within the block.
  always_comb begin
    take_bytes = 8;
    if (IN_LAST && (IN_BYTES < 4'd8)) begin
      take_bytes = int'(IN_BYTES);
    end
    pad_pos = 8 * int'(word_cnt) + take_bytes;
  end

  // Next block contents for an accepted word. The current slot is written,
  // and bytes past the valid count are masked to zero. On the last word every
  // later slot is cleared as well, so data from an earlier block cannot
  // survive. The suffix and the closing 0x80 are then OR-ed in, which makes
  // them merge into one byte when the pad starts at the final byte.
  always_comb begin
    fill_block = BLOCK_OUT;
    for (int w = 0; w < W; w++) begin
      for (int i = 0; i < 8; i++) begin
        if (w == int'(word_cnt)) begin
          if (i < take_bytes) begin
            fill_block[64*w + 8*i +: 8] = IN_DATA[63 - 8*i -: 8];
          end else begin
            fill_block[64*w + 8*i +: 8] = 8'h00;
          end
        end else if (IN_LAST && (w > int'(word_cnt))) begin
          fill_block[64*w + 8*i +: 8] = 8'h00;
        end
      end
    end
    if (IN_LAST && (pad_pos < NB)) begin
      for (int j = 0; j < NB; j++) begin
        if (j == pad_pos) begin
          fill_block[8*j +: 8] = fill_block[8*j +: 8] | SUFFIX;
        end
      end
      fill_block[8*(NB-1) +: 8] = fill_block[8*(NB-1) +: 8] | 8'h80;
    end
  end

  // Pad-only block. It is needed when the message ends exactly on a block
  // boundary.
  always_comb begin
    pad_block                 = '0;
    pad_block[0:7]            = SUFFIX;
    pad_block[8*(NB-1) +: 8]  = 8'h80;
  end

  // Main control. BLOCK_OUT also serves as the assembly buffer. This is safe
  // because no input is accepted while a block is being presented.
  always_ff @(posedge CLK or posedge A_RST) begin
    if (A_RST) begin
      state       <= FILL;
      word_cnt    <= '0;
      first_flag  <= 1'b1;
      pad_owed    <= 1'b0;
      BLOCK_OUT   <= '0;
      BLOCK_VALID <= 1'b0;
      BLOCK_FIRST <= 1'b0;
      BLOCK_LAST  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (in_xfer) begin
            BLOCK_OUT <= fill_block;
            if (IN_LAST) begin
              word_cnt    <= '0;
              state       <= EMIT;
              BLOCK_VALID <= 1'b1;
              BLOCK_FIRST <= first_flag;
              if (pad_pos == NB) begin
                BLOCK_LAST <= 1'b0;
                pad_owed   <= 1'b1;
              end else begin
                BLOCK_LAST <= 1'b1;
              end
            end else if (word_cnt == CNT_W'(W - 1)) begin
              word_cnt    <= '0;
              state       <= EMIT;
              BLOCK_VALID <= 1'b1;
              BLOCK_FIRST <= first_flag;
              BLOCK_LAST  <= 1'b0;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        EMIT: begin
          if (BLOCK_READY) begin
            BLOCK_VALID <= 1'b0;
            BLOCK_FIRST <= 1'b0;
            BLOCK_LAST  <= 1'b0;
            first_flag  <= BLOCK_LAST;
            pad_owed    <= 1'b0;
            state       <= pad_owed ? PAD : FILL;
          end
        end
        PAD: begin
          BLOCK_OUT   <= pad_block;
          BLOCK_VALID <= 1'b1;
          BLOCK_FIRST <= 1'b0;
          BLOCK_LAST  <= 1'b1;
          state       <= EMIT;
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

`ifdef SHA3_PADDER_LEN_CNT_EN
  logic [32:0] msg_bytes_sum;

  assign msg_bytes_sum = {1'b0, MSG_BYTES} + 33'(take_bytes);

  // Byte count of the message. It is final once the last word has been
  // accepted, so it stays stable while the LAST block waits. It restarts when
  // that block leaves and saturates instead of wrapping.
  always_ff @(posedge CLK or posedge A_RST) begin
    if (A_RST) begin
      MSG_BYTES <= '0;
    end else if (out_xfer && BLOCK_LAST) begin
      MSG_BYTES <= '0;
    end else if (in_xfer) begin
      MSG_BYTES <= msg_bytes_sum[32] ? 32'hFFFF_FFFF : msg_bytes_sum[31:0];
    end
  end
`else
  // Without the length counter, out_xfer has no consumer outside the FSM.
  logic unused_out_xfer;
  assign unused_out_xfer = out_xfer;
`endif

endmodule

// File: tb/tb_sha3_padder.sv
// tb_sha3_padder
//
// Bench for sha3_padder. Two instances share the same inputs: the default
// SHA-3 suffix (0x06) and the Keccak suffix (0x01). Messages are random byte
// strings. The reference pads each message as a flat byte array (message,
// suffix, zeros, closing 0x80 up to a whole number of blocks) and slices it
// into expected blocks. A monitor compares every block handshake against that
// list and checks that pending blocks stay stable.

module tb_sha3_padder;

  localparam int R  = 1152;
  localparam int NB = R / 8;

  typedef struct {
    logic [0:R-1] blk6;
    logic [0:R-1] blk1;
    logic         first;
    logic         last;
    int           len;
  } exp_t;

  logic          CLK;
  logic          A_RST;
  logic [63:0]   IN_DATA;
  logic          IN_VALID;
  logic          IN_READY;
  logic          IN_LAST;
  logic [3:0]    IN_BYTES;
  logic [0:R-1]  BLOCK_OUT;
  logic          BLOCK_VALID;
  logic          BLOCK_READY;
  logic          BLOCK_FIRST;
  logic          BLOCK_LAST;
  logic          in_ready2;
  logic [0:R-1]  block_out2;
  logic          block_valid2;
  logic          block_first2;
  logic          block_last2;
`ifdef SHA3_PADDER_LEN_CNT_EN
  logic [31:0]   msg_bytes;
  logic [31:0]   msg_bytes2;
`endif

  int            n_checks = 0;
  int            n_errors = 0;
  logic [7:0]    msg_q[$];
  exp_t          exp_q[$];
  logic          ready_rand_en = 1'b0;
  logic          ready_hold    = 1'b0;

  sha3_padder #(.R_BLOCK_SIZE(R), .SUFFIX(8'h06)) dut (
    .CLK(CLK), .A_RST(A_RST),
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_LAST(IN_LAST), .IN_BYTES(IN_BYTES),
    .BLOCK_OUT(BLOCK_OUT), .BLOCK_VALID(BLOCK_VALID), .BLOCK_READY(BLOCK_READY),
    .BLOCK_FIRST(BLOCK_FIRST), .BLOCK_LAST(BLOCK_LAST)
`ifdef SHA3_PADDER_LEN_CNT_EN
    , .MSG_BYTES(msg_bytes)
`endif
  );

  sha3_padder #(.R_BLOCK_SIZE(R), .SUFFIX(8'h01)) dut_keccak (
    .CLK(CLK), .A_RST(A_RST),
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(in_ready2),
    .IN_LAST(IN_LAST), .IN_BYTES(IN_BYTES),
    .BLOCK_OUT(block_out2), .BLOCK_VALID(block_valid2), .BLOCK_READY(BLOCK_READY),
    .BLOCK_FIRST(block_first2), .BLOCK_LAST(block_last2)
`ifdef SHA3_PADDER_LEN_CNT_EN
    , .MSG_BYTES(msg_bytes2)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [R-1:0] got, input logic [R-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: pad the whole message as a flat byte array, then slice
  // it into rate blocks.
  task automatic pushExpected();
    int         len;
    int         nblk;
    logic [7:0] p6[];
    logic [7:0] p1[];
    exp_t       e;
    len  = msg_q.size();
    nblk = len / NB + 1;
    p6 = new[nblk * NB];
    p1 = new[nblk * NB];
    for (int i = 0; i < nblk * NB; i++) begin
      p6[i] = (i < len) ? msg_q[i] : 8'h00;
      p1[i] = p6[i];
    end
    p6[len] = p6[len] | 8'h06;
    p1[len] = p1[len] | 8'h01;
    p6[nblk*NB-1] = p6[nblk*NB-1] | 8'h80;
    p1[nblk*NB-1] = p1[nblk*NB-1] | 8'h80;
    for (int b = 0; b < nblk; b++) begin
      for (int k = 0; k < NB; k++) begin
        e.blk6[8*k +: 8] = p6[b*NB + k];
        e.blk1[8*k +: 8] = p1[b*NB + k];
      end
      e.first = (b == 0);
      e.last  = (b == nblk - 1);
      e.len   = len;
      exp_q.push_back(e);
    end
  endtask

  // Present one word and hold it until accepted. Called just after a rising
  // edge; returns just after the edge that took the word.
  task automatic sendWord(input logic [63:0] d, input logic last, input logic [3:0] nb);
    int   budget;
    logic done;
    budget   = 0;
    done     = 1'b0;
    IN_DATA  = d;
    IN_LAST  = last;
    IN_BYTES = nb;
    IN_VALID = 1'b1;
    while (!done) begin
      @(negedge CLK);
      if (IN_READY) begin
        done = 1'b1;
      end else begin
        budget++;
        if (budget > 300) begin
          checkOutput("in_ready_timeout", R'(IN_READY), R'(1));
          done = 1'b1;
        end
      end
    end
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
    IN_DATA  = {$urandom, $urandom};
    IN_BYTES = 4'($urandom_range(0, 15));
  endtask

  // Send msg_q as one message, with random idle gaps of up to gap_max cycles
  // between words. Unused bytes and ignored IN_BYTES values are randomized.
  task automatic applyStimulus(input int gap_max);
    int          len;
    int          nw;
    int          nb;
    logic [63:0] d;
    logic [3:0]  nbf;
    pushExpected();
    len = msg_q.size();
    nw  = (len == 0) ? 1 : (len + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      d = {$urandom, $urandom};
      if (w == nw - 1) begin
        nb = len - 8 * w;
        for (int i = 0; i < nb; i++) d[63 - 8*i -: 8] = msg_q[8*w + i];
        nbf = (nb == 8 && $urandom_range(0, 1) == 1) ? 4'(8 + $urandom_range(0, 7)) : 4'(nb);
        sendWord(d, 1'b1, nbf);
      end else begin
        for (int i = 0; i < 8; i++) d[63 - 8*i -: 8] = msg_q[8*w + i];
        sendWord(d, 1'b0, 4'($urandom_range(0, 15)));
        repeat ($urandom_range(0, gap_max)) begin
          @(posedge CLK);
          #1;
        end
      end
    end
  endtask

  task automatic randomMessage(input int len);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
  endtask

  task automatic waitDrain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 1000) begin
      @(posedge CLK);
      #1;
      budget++;
    end
    repeat (2) begin
      @(posedge CLK);
      #1;
    end
    checkOutput("drain", R'(exp_q.size()), R'(0));
  endtask

  // Downstream ready: random, or a fixed level for the stall tests.
  initial begin
    BLOCK_READY = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      BLOCK_READY = ready_rand_en ? ($urandom_range(0, 3) != 0) : ready_hold;
    end
  end

  // Block monitor. Runs on the falling edge. A pending block that was not
  // taken must stay unchanged. A handshake about to complete is compared with
  // the head of the expected list.
  initial begin
    logic         prev_valid;
    logic         prev_xfer;
    logic [0:R-1] prev_blk;
    logic         prev_first;
    logic         prev_last;
    logic         xfer;
    exp_t         e;
    prev_valid = 1'b0;
    prev_xfer  = 1'b0;
    prev_blk   = '0;
    prev_first = 1'b0;
    prev_last  = 1'b0;
    forever begin
      @(negedge CLK);
      if (A_RST) begin
        prev_valid = 1'b0;
      end else begin
        if (prev_valid && !prev_xfer) begin
          checkOutput("hold_valid", R'(BLOCK_VALID), R'(1));
          checkOutput("hold_block", BLOCK_OUT, prev_blk);
          checkOutput("hold_first", R'(BLOCK_FIRST), R'(prev_first));
          checkOutput("hold_last", R'(BLOCK_LAST), R'(prev_last));
        end
        if (BLOCK_VALID) checkOutput("in_ready_pending", R'(IN_READY), R'(0));
        xfer = BLOCK_VALID && BLOCK_READY;
        if (xfer) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_block", R'(BLOCK_VALID), R'(0));
          end else begin
            e = exp_q.pop_front();
            checkOutput("block_sha3", BLOCK_OUT, e.blk6);
            checkOutput("first", R'(BLOCK_FIRST), R'(e.first));
            checkOutput("last", R'(BLOCK_LAST), R'(e.last));
            checkOutput("valid_keccak", R'(block_valid2), R'(1));
            checkOutput("block_keccak", block_out2, e.blk1);
            checkOutput("first_keccak", R'(block_first2), R'(e.first));
            checkOutput("last_keccak", R'(block_last2), R'(e.last));
`ifdef SHA3_PADDER_LEN_CNT_EN
            if (e.last) checkOutput("msg_bytes", R'(msg_bytes), R'(e.len));
`endif
          end
        end
        prev_valid = BLOCK_VALID;
        prev_xfer  = xfer;
        prev_blk   = BLOCK_OUT;
        prev_first = BLOCK_FIRST;
        prev_last  = BLOCK_LAST;
      end
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    A_RST    = 1'b1;
    IN_DATA  = '0;
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
    IN_BYTES = '0;

    // Reset state
    repeat (2) @(negedge CLK);
    checkOutput("rst_in_ready", R'(IN_READY), R'(0));
    checkOutput("rst_block", BLOCK_OUT, R'(0));
    checkOutput("rst_valid", R'(BLOCK_VALID), R'(0));
    checkOutput("rst_first", R'(BLOCK_FIRST), R'(0));
    checkOutput("rst_last", R'(BLOCK_LAST), R'(0));
`ifdef SHA3_PADDER_LEN_CNT_EN
    checkOutput("rst_msg_bytes", R'(msg_bytes), R'(0));
`endif
    A_RST = 1'b0;
    @(posedge CLK);
    #1;

    // Four-byte message with downstream stalled: block appears one cycle
    // after the word is accepted.
    ready_rand_en = 1'b0;
    ready_hold    = 1'b0;
    msg_q = '{8'h53, 8'h58, 8'h7B, 8'h99};
    @(negedge CLK);
    checkOutput("idle_valid", R'(BLOCK_VALID), R'(0));
    checkOutput("idle_in_ready", R'(IN_READY), R'(1));
    @(posedge CLK);
    #1;
    applyStimulus(0);
    @(negedge CLK);
    checkOutput("latency_valid", R'(BLOCK_VALID), R'(1));
    repeat (3) @(posedge CLK);
    #1;
    ready_rand_en = 1'b1;
    waitDrain();

    // Boundary lengths: empty, one short of a block, exactly a block, and
    // the same cases one block further on.
    foreach (msg_q[i]) msg_q[i] = 8'h00;
    for (int t = 0; t < 9; t++) begin
      int lens[9] = '{0, 143, 144, 136, 135, 8, 287, 288, 145};
      randomMessage(lens[t]);
      applyStimulus(1);
    end
    waitDrain();

    // Downstream stalled for ten cycles with a block pending.
    ready_rand_en = 1'b0;
    ready_hold    = 1'b0;
    @(posedge CLK);
    #1;
    randomMessage(20);
    applyStimulus(0);
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      checkOutput("stall_valid", R'(BLOCK_VALID), R'(1));
      checkOutput("stall_in_ready", R'(IN_READY), R'(0));
    end
    @(posedge CLK);
    #1;
    ready_hold = 1'b1;
    waitDrain();

    // Back-to-back messages with no gap between them.
    ready_rand_en = 1'b1;
    randomMessage(13);
    applyStimulus(0);
    randomMessage(150);
    applyStimulus(0);
    waitDrain();

    // Reset after five words of a long message.
    for (int w = 0; w < 5; w++) sendWord({$urandom, $urandom}, 1'b0, 4'd8);
    @(posedge CLK);
    #3;
    A_RST = 1'b1;
    #1;
    checkOutput("midrst_in_ready", R'(IN_READY), R'(0));
    checkOutput("midrst_block", BLOCK_OUT, R'(0));
    checkOutput("midrst_valid", R'(BLOCK_VALID), R'(0));
    checkOutput("midrst_first", R'(BLOCK_FIRST), R'(0));
    checkOutput("midrst_last", R'(BLOCK_LAST), R'(0));
`ifdef SHA3_PADDER_LEN_CNT_EN
    checkOutput("midrst_msg_bytes", R'(msg_bytes), R'(0));
`endif
    repeat (2) @(negedge CLK);
    A_RST = 1'b0;
    @(posedge CLK);
    #1;
    randomMessage(4);
    applyStimulus(0);
    waitDrain();

    // Random messages with random gaps and random downstream ready.
    for (int m = 0; m < 30; m++) begin
      randomMessage($urandom_range(0, 320));
      applyStimulus(2);
    end
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
